// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the 8x32 FIFO buffer and its read/write controllers:
// word/byte geometry, FIFO depth, the drain FSM state encoding, and a helper
// that picks one byte out of a word in either transmit order.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int FIFO_DEPTH     = 8;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [IDX_W-1:0]  byte_idx_t;

    // Drain FSM: IDLE decides, REQ carries the read strobe, WAIT captures the
    // FIFO's registered output, SEND streams the bytes.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } drain_state_e;

    // Byte number idx of the transmit sequence. With MSB-first order the
    // position is mirrored; ~idx equals (BYTES_PER_WORD-1-idx) because the
    // byte count is a power of two.
    function automatic byte_t pick_byte(input word_t w, input byte_idx_t idx,
                                        input bit lsb_first);
        byte_idx_t pos;
        pos = lsb_first ? idx : ~idx;
        return w[BYTE_W*pos +: BYTE_W];
    endfunction

endpackage

// File: rtl/fifo_drain_serializer_if.sv
// -----------------------------------------------------------------------------
// fifo_drain_serializer_if
// Byte-wide valid/ready stream carrying one byte per beat plus a last marker.
//   m_valid : producer has a byte on m_data
//   m_ready : consumer accepts the byte this cycle
//   m_data  : byte payload
//   m_last  : final byte of a word
// master = producer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface fifo_drain_serializer_if;
    import fifo_pkg::*;

    logic  m_valid;
    logic  m_ready;
    byte_t m_data;
    logic  m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/fifo_drain_serializer_word_byte_shifter.sv
// -----------------------------------------------------------------------------
// word_byte_shifter
// Holds one captured 32-bit word and walks through its four bytes.
//   clock, reset : clock and synchronous active-high reset
//   load_i       : capture word_i and restart at byte 0
//   word_i       : word to capture
//   advance_i    : current byte was accepted, move to the next one
//   byte_o       : current byte in the order chosen by LSB_FIRST
//   last_o       : current byte is the final one of the word
// -----------------------------------------------------------------------------
module word_byte_shifter
    import fifo_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  load_i,
    input  word_t word_i,
    input  logic  advance_i,
    output byte_t byte_o,
    output logic  last_o
);

    word_t     word_q;
    byte_idx_t idx_q;

    // NOTE: the word register is cleared on reset as well, so a byte left
    // over from an aborted word can never reappear on the output.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            word_q <= word_i;
            idx_q  <= '0;
        end else if (advance_i) begin
            idx_q  <= idx_q + 1'b1;
        end
    end

    assign byte_o = pick_byte(word_q, idx_q, LSB_FIRST);
    assign last_o = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/fifo_drain_serializer.sv
// -----------------------------------------------------------------------------
// fifo_drain_serializer
// Read-side controller for the 8x32 FIFO: issues one read pulse per word,
// captures the FIFO's registered data output and streams it as four bytes.
//   clock, reset   : clock and synchronous active-high reset
//   drain_en_i     : permits starting a new word fetch
//   fifo_empty_i   : FIFO empty flag, looked at only in IDLE
//   fifo_read_o    : registered read strobe, one cycle per word
//   fifo_data_i    : FIFO data_out, valid the cycle after the read edge
//   m_if           : byte stream out (master modport)
//   busy_o         : FSM is anywhere but IDLE
//   words_sent_o   : count of fully transmitted words, wraps silently
// -----------------------------------------------------------------------------
module fifo_drain_serializer
    import fifo_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      drain_en_i,
    input  logic                      fifo_empty_i,
    output logic                      fifo_read_o,
    input  word_t                     fifo_data_i,
    fifo_drain_serializer_if.master   m_if,
    output logic                      busy_o,
    output logic [CNT_W-1:0]          words_sent_o
);

    drain_state_e     state_q, state_d;
    logic             fifo_read_q, fifo_read_d;
    logic [CNT_W-1:0] words_sent_q, words_sent_d;

    logic  load_word;
    logic  byte_accept;
    byte_t cur_byte;
    logic  cur_last;
    logic  sending;

    // NOTE: every variable driven here gets a default before the case, so
    // no path through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        fifo_read_d  = 1'b0;
        words_sent_d = words_sent_q;
        load_word    = 1'b0;
        byte_accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (drain_en_i && !fifo_empty_i) begin
                    state_d     = REQ;
                    fifo_read_d = 1'b1;   // strobe is high during REQ only
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                load_word = 1'b1;         // FIFO data_out is valid now
                state_d   = SEND;
            end
            SEND: begin
                byte_accept = m_if.m_ready;
                if (m_if.m_ready && cur_last) begin
                    words_sent_d = words_sent_q + 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            fifo_read_q  <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            fifo_read_q  <= fifo_read_d;
            words_sent_q <= words_sent_d;
        end
    end

    word_byte_shifter #(
        .LSB_FIRST (LSB_FIRST)
    ) u_shifter (
        .clock     (clock),
        .reset     (reset),
        .load_i    (load_word),
        .word_i    (fifo_data_i),
        .advance_i (byte_accept),
        .byte_o    (cur_byte),
        .last_o    (cur_last)
    );

    // Stream outputs depend only on registered state, never on m_ready, and
    // are forced to zero outside SEND.
    assign sending      = (state_q == SEND);
    assign m_if.m_valid = sending;
    assign m_if.m_data  = sending ? cur_byte : '0;
    assign m_if.m_last  = sending && cur_last;

    assign fifo_read_o  = fifo_read_q;
    assign busy_o       = (state_q != IDLE);
    assign words_sent_o = words_sent_q;

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain_serializer
// Two serializers share one stimulus: lane 0 is LSB-first with a 16-bit word
// counter, lane 1 is MSB-first with a 3-bit counter so wrap-around is reached
// in a short run. Each lane has its own 8x32 FIFO model with registered
// data_out. A scoreboard knows the ordered list of pushed words and derives
// every expected byte, last flag and counter value from it.
// -----------------------------------------------------------------------------
module tb_fifo_drain_serializer;
    import fifo_pkg::*;

    localparam int CNT_W0 = 16;
    localparam int CNT_W1 = 3;

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic drain_en = 1'b0;
    logic ready    = 1'b0;

    always #5 clock = ~clock;

    fifo_drain_serializer_if ifc0 ();
    fifo_drain_serializer_if ifc1 ();
    assign ifc0.m_ready = ready;
    assign ifc1.m_ready = ready;

    logic [1:0]        fifo_empty;
    logic [1:0]        fifo_read;
    logic [1:0]        busy;
    word_t             fifo_data [2] = '{32'h0, 32'h0};
    logic [CNT_W0-1:0] ws0;
    logic [CNT_W1-1:0] ws1;

    fifo_drain_serializer #(.LSB_FIRST(1'b1), .CNT_W(CNT_W0)) dut0 (
        .clock        (clock),
        .reset        (reset),
        .drain_en_i   (drain_en),
        .fifo_empty_i (fifo_empty[0]),
        .fifo_read_o  (fifo_read[0]),
        .fifo_data_i  (fifo_data[0]),
        .m_if         (ifc0),
        .busy_o       (busy[0]),
        .words_sent_o (ws0)
    );

    fifo_drain_serializer #(.LSB_FIRST(1'b0), .CNT_W(CNT_W1)) dut1 (
        .clock        (clock),
        .reset        (reset),
        .drain_en_i   (drain_en),
        .fifo_empty_i (fifo_empty[1]),
        .fifo_read_o  (fifo_read[1]),
        .fifo_data_i  (fifo_data[1]),
        .m_if         (ifc1),
        .busy_o       (busy[1]),
        .words_sent_o (ws1)
    );

    // ---------------- FIFO models ----------------
    logic  push_v = 1'b0;
    word_t push_d = '0;
    word_t mem  [2][FIFO_DEPTH];
    int    wr_p [2] = '{0, 0};
    int    rd_p [2] = '{0, 0};
    int    cnt  [2] = '{0, 0};

    always @(posedge clock) begin
        for (int l = 0; l < 2; l++) begin
            if (fifo_read[l] && cnt[l] > 0) begin
                fifo_data[l] <= mem[l][rd_p[l]];
                rd_p[l]      <= (rd_p[l] + 1) % FIFO_DEPTH;
            end
            if (push_v) begin
                mem[l][wr_p[l]] <= push_d;
                wr_p[l]         <= (wr_p[l] + 1) % FIFO_DEPTH;
            end
            cnt[l] <= cnt[l] + (push_v ? 1 : 0) - ((fifo_read[l] && cnt[l] > 0) ? 1 : 0);
        end
    end

    assign fifo_empty[0] = (cnt[0] == 0);
    assign fifo_empty[1] = (cnt[1] == 0);

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    word_t words_a [$];          // every word pushed, in order
    int    acc      [2] = '{0, 0};        // stream byte position per lane
    logic [15:0] ws_exp [2] = '{16'h0, 16'h0};
    int    reads    [2] = '{0, 0};
    int    last_rd_cyc [2] = '{-100, -100};
    byte_t log_b    [2][128];
    int    log_n    [2] = '{0, 0};
    logic  prev_valid [2] = '{1'b0, 1'b0};
    logic  prev_acc   [2] = '{1'b0, 1'b0};
    logic  prev_rd    [2] = '{1'b0, 1'b0};
    logic  prev_ok    [2] = '{1'b0, 1'b0};
    byte_t prev_data  [2] = '{8'h0, 8'h0};
    logic  prev_last  [2] = '{1'b0, 1'b0};
    logic  prev_reset = 1'b1;
    int    cyc = 0;

    // Byte p of word w goes out at position p (LSB-first) or 3-p (MSB-first).
    function automatic byte_t exp_byte(input int lane, input int k);
        word_t w;
        int    p;
        w = words_a[k / 4];
        p = (lane == 0) ? (k % 4) : (3 - k % 4);
        return byte_t'(w >> (8 * p));
    endfunction

    task automatic compare_lane(input int l);
        logic        v, lst, rd;
        byte_t       d;
        logic [15:0] ws;
        string       ln;
        ln = (l == 0) ? "lane0" : "lane1";
        v   = (l == 0) ? ifc0.m_valid : ifc1.m_valid;
        lst = (l == 0) ? ifc0.m_last  : ifc1.m_last;
        d   = (l == 0) ? ifc0.m_data  : ifc1.m_data;
        rd  = fifo_read[l];
        ws  = (l == 0) ? ws0 : 16'(ws1);

        check({ln, " words_sent"}, 32'(ws), 32'(ws_exp[l]));
        if (rd) begin
            check({ln, " read_back_to_back"}, 32'(prev_rd[l]), 32'd0);
            check({ln, " read_without_data"}, 32'(prev_ok[l]), 32'd1);
            reads[l]++;
            last_rd_cyc[l] = cyc;
        end
        if (!v) begin
            check({ln, " idle_data"}, 32'(d), 32'd0);
            check({ln, " idle_last"}, 32'(lst), 32'd0);
            if (prev_valid[l] && !prev_acc[l] && !prev_reset)
                check({ln, " valid_dropped"}, 32'(v), 32'd1);
        end else begin
            if (!prev_valid[l])
                check({ln, " first_byte_latency"}, 32'(cyc - last_rd_cyc[l]), 32'd2);
            if (prev_valid[l] && !prev_acc[l] && !prev_reset) begin
                check({ln, " stall_data"}, 32'(d), 32'(prev_data[l]));
                check({ln, " stall_last"}, 32'(lst), 32'(prev_last[l]));
            end
            if (acc[l] / 4 < words_a.size()) begin
                check({ln, " byte"}, 32'(d), 32'(exp_byte(l, acc[l])));
                check({ln, " last"}, 32'(lst), 32'(acc[l] % 4 == 3));
            end else begin
                check({ln, " unexpected_byte"}, 32'(v), 32'd0);
            end
        end

        // Account for what the coming rising edge does.
        prev_valid[l] = v;
        prev_data[l]  = d;
        prev_last[l]  = lst;
        prev_rd[l]    = rd;
        prev_ok[l]    = drain_en && !fifo_empty[l];
        prev_acc[l]   = v && ready && !reset;
        if (reset) begin
            if (acc[l] % 4 != 0) acc[l] += 4 - acc[l] % 4;   // aborted word is dropped
            ws_exp[l] = '0;
        end else if (v && ready) begin
            log_b[l][log_n[l] % 128] = d;
            log_n[l]++;
            if (acc[l] % 4 == 3)
                ws_exp[l] = (ws_exp[l] + 16'd1) & ((l == 0) ? 16'hFFFF : 16'h0007);
            acc[l]++;
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        compare_lane(0);
        compare_lane(1);
        prev_reset = reset;
    end

    // ---------------- stimulus ----------------
    int ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0 repeating
    int phase      = 0;

    task automatic tick();
        @(posedge clock);
        #1;
        phase++;
        ready = (ready_mode == 0) ? 1'b1 : (phase % 3 == 0);
    endtask

    task automatic push(input word_t w);
        push_v = 1'b1;
        push_d = w;
        words_a.push_back(w);
        tick();
        push_v = 1'b0;
    endtask

    task automatic wait_ws0(input int target, input int budget);
        for (int i = 0; i < budget && int'(ws0) != target; i++) tick();
        check("wait_words_sent", 32'(ws0), 32'(target));
    endtask

    task automatic check_bytes(input int l, input int base, input logic [31:0] seq);
        for (int i = 0; i < 4; i++)
            check($sformatf("lane%0d log[%0d]", l, base + i), 32'(log_b[l][base + i]),
                  32'(seq[31 - 8*i -: 8]));
    endtask

    initial begin
        // Reset and idle with an empty FIFO.
        repeat (3) tick();
        for (int l = 0; l < 2; l++) check("reset fifo_read", 32'(fifo_read[l]), 32'd0);
        check("reset valid0", 32'(ifc0.m_valid), 32'd0);
        check("reset data0", 32'(ifc0.m_data), 32'd0);
        check("reset last1", 32'(ifc1.m_last), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ws0", 32'(ws0), 32'd0);
        reset    = 1'b0;
        drain_en = 1'b1;
        repeat (20) tick();
        check("empty reads0", 32'(reads[0]), 32'd0);
        check("empty busy", 32'(busy), 32'd0);
        check("empty valid1", 32'(ifc1.m_valid), 32'd0);

        // One word, consumer always ready.
        push(32'hA1B2C3D4);
        wait_ws0(1, 40);
        check_bytes(0, 0, 32'hD4C3B2A1);
        check_bytes(1, 0, 32'hA1B2C3D4);
        check("one word reads0", 32'(reads[0]), 32'd1);
        check("one word reads1", 32'(reads[1]), 32'd1);
        check("one word ws1", 32'(ws1), 32'd1);

        // Same word with a stalling consumer.
        ready_mode = 1;
        push(32'hA1B2C3D4);
        wait_ws0(2, 80);
        check_bytes(0, 4, 32'hD4C3B2A1);
        check_bytes(1, 4, 32'hA1B2C3D4);
        ready_mode = 0;

        // Fill the FIFO with eight words, then drain.
        drain_en = 1'b0;
        for (int i = 0; i < 8; i++) push(word_t'(i));
        check("fill count", 32'(cnt[0]), 32'd8);
        drain_en = 1'b1;
        wait_ws0(10, 200);
        check("fill reads0", 32'(reads[0]), 32'd10);
        check("fill reads1", 32'(reads[1]), 32'd10);
        check("fill empty", 32'(fifo_empty), 32'h3);
        check("fill busy", 32'(busy), 32'd0);
        check("fill ws1 wrapped", 32'(ws1), 32'd2);
        check("fill bytes", 32'(log_n[0]), 32'd40);
        check("fill lane0 word7", 32'(log_b[0][36]), 32'h07);
        check("fill lane1 word7", 32'(log_b[1][39]), 32'h07);

        // Reset after the second byte of a word.
        push(32'h11223344);
        for (int i = 0; i < 40 && acc[0] < 42; i++) tick();
        check("reset point", 32'(acc[0]), 32'd42);
        reset = 1'b1;
        tick();
        check("abort valid0", 32'(ifc0.m_valid), 32'd0);
        check("abort valid1", 32'(ifc1.m_valid), 32'd0);
        check("abort ws0", 32'(ws0), 32'd0);
        check("abort ws1", 32'(ws1), 32'd0);
        reset = 1'b0;
        repeat (10) tick();
        check("abort reads0", 32'(reads[0]), 32'd11);
        check("abort bytes0", 32'(log_n[0]), 32'd42);
        check("abort idle", 32'(busy), 32'd0);

        // A following word streams normally.
        push(32'h55667788);
        wait_ws0(1, 40);
        check_bytes(0, 42, 32'h88776655);
        check_bytes(1, 42, 32'h55667788);

        // Counter wrap on the 3-bit lane.
        for (int i = 0; i < 6; i++) push(32'h100 + word_t'(i));
        wait_ws0(7, 200);
        check("pre-wrap ws1", 32'(ws1), 32'd7);
        push(32'hDEADBEEF);
        wait_ws0(8, 40);
        check("wrap ws1", 32'(ws1), 32'd0);
        check("no wrap ws0", 32'(ws0), 32'd8);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
